dvi_tmds_pipe: RTL and testbench

Pixel-clock-domain front end of the DVI transmitter. Takes raw sync, DE, control bits and per-channel colour, then:
- aligns sync/DE with the pixel data through a programmable delay line;
- applies sync polarity;
- TMDS-encodes NUM_CH channels in parallel, each with its own running-disparity counter.

Its output 10-bit words feed the per-channel serializers. It generalises the earlier fixed 3-channel, 8-bit, 1-cycle-alignment encode path to configurable colour width, channel count, alignment depth and sync polarity, and adds a force-black mode.

---
 rtl/dvi_tmds_pipe.sv | 187 ++++++++++++++++++
 tb/tb_dvi_tmds_pipe.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_tmds_pipe.sv
// -----------------------------------------------------------------------------
// dvi_tmds_pipe
//
// Pixel-clock front end of the DVI transmitter. Sync, DE and control bits are
// aligned to the pixel data through a programmable delay line. Sync polarity is
// then applied, and NUM_CH channels are TMDS-encoded in parallel. Each channel
// keeps its own running-disparity counter. The output words go to the
// per-channel serializers.
//
// Ports:
//   clk_i          pixel clock
//   rst_ni         asynchronous reset, active low
//   hsync_i        logical horizontal sync (1 = inside sync pulse)
//   vsync_i        logical vertical sync   (1 = inside sync pulse)
//   de_i           data enable (visible range)
//   ctl_i          C1/C0 pairs for channels 1..NUM_CH-1, pair k at [2k-1:2k-2]
//                  (C0 is the lower bit). When NUM_CH=1 this is a single unused
//                  bit, because a zero-width port is not legal.
//   pixel_i        colour, channel c at [c*COLOR_W +: COLOR_W]
//   force_black_i  during DE, encode 0x00 on all channels in place of pixel_i
//   tmds_o         10-bit TMDS words, channel c at [c*10 +: 10], bit 0 sent first
//
// Latency: pixel_i and force_black_i take 1 cycle to reach tmds_o.
//          hsync/vsync/de/ctl take SYNC_DELAY+1 cycles.
// -----------------------------------------------------------------------------
module dvi_tmds_pipe #(
    parameter int unsigned NUM_CH         = 3,
    parameter int unsigned COLOR_W        = 8,
    parameter int unsigned SYNC_DELAY     = 1,
    parameter bit          HSYNC_ACT_HIGH = 1'b1,
    parameter bit          VSYNC_ACT_HIGH = 1'b1,
    localparam int unsigned CTL_W         = (NUM_CH > 1) ? 2 * NUM_CH - 2 : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      hsync_i,
    input  logic                      vsync_i,
    input  logic                      de_i,
    input  logic [CTL_W-1:0]          ctl_i,
    input  logic [NUM_CH*COLOR_W-1:0] pixel_i,
    input  logic                      force_black_i,
    output logic [NUM_CH*10-1:0]      tmds_o
);

    // Control-period tokens, indexed by {C1, C0}.
    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    // Bundle carried through the delay line: {ctl, de, vsync, hsync}.
    localparam int unsigned SW = CTL_W + 3;

    logic [SW-1:0]    sync_in;
    logic [SW-1:0]    sync_dly;
    logic             hs_dly;
    logic             vs_dly;
    logic             de_dly;
    logic [CTL_W-1:0] ctl_dly;
    logic             hsync_pol;
    logic             vsync_pol;

    assign sync_in = {ctl_i, de_i, vsync_i, hsync_i};

    // -------------------------------------------------------------------------
    // Sync/DE/control alignment delay line
    // -------------------------------------------------------------------------
    if (SYNC_DELAY == 0) begin : g_no_dly
        assign sync_dly = sync_in;
    end else begin : g_dly
        logic [SW-1:0] stage_q [SYNC_DELAY];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < int'(SYNC_DELAY); i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= sync_in;
                for (int i = 1; i < int'(SYNC_DELAY); i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign sync_dly = stage_q[SYNC_DELAY-1];
    end

    assign hs_dly  = sync_dly[0];
    assign vs_dly  = sync_dly[1];
    assign de_dly  = sync_dly[2];
    assign ctl_dly = sync_dly[SW-1:3];

    // Convert logical sync into the on-wire C0/C1 level for channel 0.
    assign hsync_pol = HSYNC_ACT_HIGH ? hs_dly : ~hs_dly;
    assign vsync_pol = VSYNC_ACT_HIGH ? vs_dly : ~vs_dly;

    // -------------------------------------------------------------------------
    // Per-channel TMDS encoder
    // -------------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]         ctrl;      // {C1, C0}
        logic [COLOR_W-1:0] color;
        logic [7:0]         color8;
        logic [7:0]         d8;
        logic [3:0]         n1_d;
        logic               use_xnor;
        logic               acc;
        logic [8:0]         q_m;
        logic [3:0]         n1_q;
        logic signed [4:0]  bal;       // N1(q_m[7:0]) - N0(q_m[7:0])
        logic signed [4:0]  cnt_q;
        logic signed [4:0]  cnt_d;
        logic [9:0]         word_q;
        logic [9:0]         word_d;

        if (c == 0) begin : g_sync_ctrl
            assign ctrl = {vsync_pol, hsync_pol};
        end else begin : g_pair_ctrl
            assign ctrl = ctl_dly[2*c-1 -: 2];
        end

        assign color = pixel_i[c*COLOR_W +: COLOR_W];

        // Widen to 8 bits by repeating the colour MSB-first.
        for (genvar i = 0; i < 8; i++) begin : g_expand
            assign color8[7-i] = color[COLOR_W-1-(i % COLOR_W)];
        end

        // Stage 1: transition minimisation.
        always_comb begin
            d8       = force_black_i ? 8'h00 : color8;
            n1_d     = 4'($countones(d8));
            use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d8[0]);
            acc      = d8[0];
            q_m      = '0;
            q_m[0]   = acc;
            for (int i = 1; i < 8; i++) begin
                acc    = use_xnor ? ~(acc ^ d8[i]) : (acc ^ d8[i]);
                q_m[i] = acc;
            end
            q_m[8] = ~use_xnor;
        end

        // N1 - N0 over 8 bits is 2*N1 - 8. Modulo-32 arithmetic is exact here
        // because both the balance and the counter stay within +/-10.
        assign n1_q = 4'($countones(q_m[7:0]));
        assign bal  = $signed({n1_q, 1'b0}) - 5'sd8;

        // Stage 2: DC balancing, or a control token during blanking.
        always_comb begin
            word_d = TOK_00;
            cnt_d  = '0;
            if (!de_dly) begin
                case (ctrl)
                    2'b00:   word_d = TOK_00;
                    2'b01:   word_d = TOK_01;
                    2'b10:   word_d = TOK_10;
                    default: word_d = TOK_11;
                endcase
            end else if ((cnt_q == 5'sd0) || (n1_q == 4'd4)) begin
                word_d = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
                cnt_d  = q_m[8] ? (cnt_q + bal) : (cnt_q - bal);
            end else if ((!cnt_q[4] && (n1_q > 4'd4)) || (cnt_q[4] && (n1_q < 4'd4))) begin
                // Running disparity would grow: invert the data bits.
                word_d = {1'b1, q_m[8], ~q_m[7:0]};
                cnt_d  = cnt_q + (q_m[8] ? 5'sd2 : 5'sd0) - bal;
            end else begin
                word_d = {1'b0, q_m[8], q_m[7:0]};
                cnt_d  = cnt_q - (q_m[8] ? 5'sd0 : 5'sd2) + bal;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                word_q <= TOK_00;
                cnt_q  <= '0;
            end else begin
                word_q <= word_d;
                cnt_q  <= cnt_d;
            end
        end

        assign tmds_o[c*10 +: 10] = word_q;
    end

endmodule

// File: tb/tb_dvi_tmds_pipe.sv
// Self-checking bench for dvi_tmds_pipe. It drives two instances with
// different configurations from the same sync/DE stimulus:
//   A: 4 channels, 8-bit colour, 2-cycle sync delay, active-high syncs
//   B: 3 channels, 4-bit colour, no sync delay, active-low hsync
// A reference model computes every output word from the encoding rules.
// Literal expectations at key points pin the model itself.
module tb_dvi_tmds_pipe;

    localparam int A_NCH = 4;
    localparam int A_CW  = 8;
    localparam int A_DLY = 2;
    localparam bit A_HH  = 1'b1;
    localparam bit A_VH  = 1'b1;
    localparam int B_NCH = 3;
    localparam int B_CW  = 4;
    localparam int B_DLY = 0;
    localparam bit B_HH  = 1'b0;
    localparam bit B_VH  = 1'b1;

    logic        clk;
    logic        rst_n;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        fb;
    logic [5:0]  ctl_a;
    logic [3:0]  ctl_b;
    logic [31:0] pixel_a;
    logic [11:0] pixel_b;
    logic [39:0] tmds_a;
    logic [29:0] tmds_b;

    int checks = 0;
    int errors = 0;

    dvi_tmds_pipe #(
        .NUM_CH(A_NCH), .COLOR_W(A_CW), .SYNC_DELAY(A_DLY),
        .HSYNC_ACT_HIGH(A_HH), .VSYNC_ACT_HIGH(A_VH)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .hsync_i(hsync), .vsync_i(vsync), .de_i(de),
        .ctl_i(ctl_a), .pixel_i(pixel_a), .force_black_i(fb), .tmds_o(tmds_a)
    );

    dvi_tmds_pipe #(
        .NUM_CH(B_NCH), .COLOR_W(B_CW), .SYNC_DELAY(B_DLY),
        .HSYNC_ACT_HIGH(B_HH), .VSYNC_ACT_HIGH(B_VH)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .hsync_i(hsync), .vsync_i(vsync), .de_i(de),
        .ctl_i(ctl_b), .pixel_i(pixel_b), .force_black_i(fb), .tmds_o(tmds_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------- model
    logic [8:0] hist_a[$];
    logic [8:0] hist_b[$];
    int         cnt_a[4];
    int         cnt_b[3];
    logic [9:0] exp_a[4];
    logic [9:0] exp_b[3];

    // Replicate the colour eight times and keep the top byte.
    function automatic logic [7:0] expand(input logic [7:0] col, input int cw);
        logic [63:0] rep;
        rep = '0;
        for (int r = 0; r < 8; r++) rep = (rep << cw) | 64'(col);
        return 8'(rep >> (8 * cw - 8));
    endfunction

    function automatic logic [9:0] ref_enc(input bit de_v, input bit [1:0] c10,
                                           input logic [7:0] d, inout int cnt);
        logic [8:0] qm;
        int n1d, n1, n0, q8;
        bit xn;
        logic [9:0] w;
        if (!de_v) begin
            cnt = 0;
            case (c10)
                2'b00:   w = 10'b1101010100;
                2'b01:   w = 10'b0010101011;
                2'b10:   w = 10'b0101010100;
                default: w = 10'b1010101011;
            endcase
            return w;
        end
        n1d   = $countones(d);
        xn    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm    = '0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        q8    = xn ? 0 : 1;
        n1    = $countones(qm[7:0]);
        n0    = 8 - n1;
        if (cnt == 0 || n1 == n0) begin
            w   = {!qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt = cnt + (q8 == 1 ? n1 - n0 : n0 - n1);
        end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
            w   = {1'b1, qm[8], ~qm[7:0]};
            cnt = cnt + 2 * q8 + (n0 - n1);
        end else begin
            w   = {1'b0, qm[8], qm[7:0]};
            cnt = cnt - (2 * (1 - q8) - (n1 - n0));
        end
        return w;
    endfunction

    task automatic init_model();
        hist_a.delete();
        hist_b.delete();
        for (int c = 0; c < A_NCH; c++) begin cnt_a[c] = 0; exp_a[c] = 10'h354; end
        for (int c = 0; c < B_NCH; c++) begin cnt_b[c] = 0; exp_b[c] = 10'h354; end
    endtask

    task automatic model_step();
        logic [8:0] s;
        logic [1:0] c10;
        logic [7:0] d;
        hist_a.push_back({ctl_a, de, vsync, hsync});
        s = (hist_a.size() > A_DLY) ? hist_a[hist_a.size() - 1 - A_DLY] : 9'h0;
        if (hist_a.size() > 20) void'(hist_a.pop_front());
        for (int c = 0; c < A_NCH; c++) begin
            if (c == 0) c10 = {s[1] ^ !A_VH, s[0] ^ !A_HH};
            else        c10 = 2'(s >> (2 * c + 1));
            d = fb ? 8'h00 : expand(8'((pixel_a >> (c * A_CW)) & ((1 << A_CW) - 1)), A_CW);
            exp_a[c] = ref_enc(s[2], c10, d, cnt_a[c]);
        end
        hist_b.push_back({2'b00, ctl_b, de, vsync, hsync});
        s = (hist_b.size() > B_DLY) ? hist_b[hist_b.size() - 1 - B_DLY] : 9'h0;
        if (hist_b.size() > 20) void'(hist_b.pop_front());
        for (int c = 0; c < B_NCH; c++) begin
            if (c == 0) c10 = {s[1] ^ !B_VH, s[0] ^ !B_HH};
            else        c10 = 2'(s >> (2 * c + 1));
            d = fb ? 8'h00 : expand(8'((pixel_b >> (c * B_CW)) & ((1 << B_CW) - 1)), B_CW);
            exp_b[c] = ref_enc(s[2], c10, d, cnt_b[c]);
        end
    endtask

    initial begin
        init_model();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) init_model();
            else        model_step();
        end
    end

    // Compare every channel of both instances against the model each cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < A_NCH; c++) begin
                checks++;
                if (tmds_a[c*10 +: 10] !== exp_a[c]) begin
                    errors++;
                    $display("FAIL model_a ch%0d t=%0t got=%h want=%h",
                             c, $time, tmds_a[c*10 +: 10], exp_a[c]);
                end
            end
            for (int c = 0; c < B_NCH; c++) begin
                checks++;
                if (tmds_b[c*10 +: 10] !== exp_b[c]) begin
                    errors++;
                    $display("FAIL model_b ch%0d t=%0t got=%h want=%h",
                             c, $time, tmds_b[c*10 +: 10], exp_b[c]);
                end
            end
        end
    end

    // ------------------------------------------------------- directed part
    function automatic logic [9:0] wa(input int c);
        return tmds_a[c*10 +: 10];
    endfunction

    function automatic logic [9:0] wb(input int c);
        return tmds_b[c*10 +: 10];
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0; de = 1'b0; fb = 1'b0;
        ctl_a = '0; ctl_b = '0; pixel_a = '0; pixel_b = '0;

        // Reset holds the 00 token whatever the inputs do.
        repeat (3) begin
            step();
            hsync = ~hsync; de = ~de; vsync = ~vsync; ctl_a = ~ctl_a;
            pixel_a = pixel_a + 32'h1234_5678; pixel_b = pixel_b + 12'h5A7;
        end
        check("rst_a_ch0", wa(0), 10'h354);
        check("rst_b_ch0", wb(0), 10'h354);
        hsync = 1'b0; vsync = 1'b0; de = 1'b0; ctl_a = '0; pixel_a = '0; pixel_b = '0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        check("idle_a_ch0", wa(0), 10'h354);
        check("idle_b_ch0_hs_low", wb(0), 10'h0AB);

        // One-cycle hsync pulse, sampled at edge k.
        hsync = 1'b1;
        step();
        check("hs_b_k", wb(0), 10'h354);
        check("hs_a_k", wa(0), 10'h354);
        hsync = 1'b0;
        step();
        check("hs_a_k1", wa(0), 10'h354);
        check("hs_b_k1", wb(0), 10'h0AB);
        step();
        check("hs_a_k2", wa(0), 10'h0AB);
        step();
        check("hs_a_k3", wa(0), 10'h354);

        // Distinct control pairs per channel, plus vsync.
        vsync = 1'b1; ctl_a = 6'b11_10_01; ctl_b = 4'b01_10;
        repeat (3) step();
        check("ctl_a_ch0", wa(0), 10'h154);
        check("ctl_a_ch1", wa(1), 10'h0AB);
        check("ctl_a_ch2", wa(2), 10'h154);
        check("ctl_a_ch3", wa(3), 10'h2AB);
        check("ctl_b_ch0", wb(0), 10'h2AB);
        check("ctl_b_ch1", wb(1), 10'h154);
        check("ctl_b_ch2", wb(2), 10'h0AB);
        vsync = 1'b0; ctl_a = '0; ctl_b = '0;
        repeat (3) step();

        // Black run of four DE cycles.
        fb = 1'b1; pixel_a = 32'hDEAD_BEEF; pixel_b = 12'h5A3; de = 1'b1;
        step();
        check("blk_b0_ch0", wb(0), 10'h100);
        check("blk_b0_ch2", wb(2), 10'h100);
        check("blk_a0_ch1", wa(1), 10'h354);
        step();
        check("blk_b1_ch1", wb(1), 10'h3FF);
        step();
        check("blk_b2_ch0", wb(0), 10'h100);
        check("blk_a2_ch0", wa(0), 10'h100);
        check("blk_a2_ch3", wa(3), 10'h100);
        step();
        check("blk_b3_ch2", wb(2), 10'h3FF);
        check("blk_a3_ch2", wa(2), 10'h3FF);
        de = 1'b0;
        step();
        check("blk_b4_ch1", wb(1), 10'h354);
        check("blk_b4_ch0", wb(0), 10'h0AB);
        check("blk_a4_ch1", wa(1), 10'h100);
        step();
        check("blk_a5_ch1", wa(1), 10'h3FF);
        step();
        check("blk_a6_ch1", wa(1), 10'h354);
        fb = 1'b0;
        step();

        // 4-bit colour expansion, starting from a cleared counter.
        pixel_b = {4'hA, 4'h0, 4'hF}; de = 1'b1;
        step();
        check("exp_b_F", wb(0), 10'h200);
        check("exp_b_0", wb(1), 10'h100);
        check("exp_b_A", wb(2), 10'h233);

        // Mixed colours per channel with short blanking gaps.
        for (int i = 0; i < 24; i++) begin
            pixel_a = {8'(i * 29 + 3), 8'(i * 53 + 17), 8'(i * 7), 8'(255 - i * 13)};
            pixel_b = {4'(i * 3 + 1), 4'(i * 5), 4'(15 - i)};
            de      = (i % 11) != 10;
            hsync   = (i % 11) == 10;
            step();
        end
        de = 1'b0; hsync = 1'b0;
        repeat (3) step();

        // Reset in the middle of a DE run with nonzero disparity.
        de = 1'b1; fb = 1'b1;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_a_ch0", wa(0), 10'h354);
        check("mid_rst_a_ch2", wa(2), 10'h354);
        check("mid_rst_b_ch0", wb(0), 10'h354);
        step();
        hsync = 1'b1; pixel_a = 32'h0F0F_0F0F;
        step();
        hsync = 1'b0;
        rst_n = 1'b1;
        step();
        check("post_rst_b_ch0", wb(0), 10'h100);
        check("post_rst_b_ch1", wb(1), 10'h100);
        check("post_rst_a_e1", wa(1), 10'h354);
        step();
        check("post_rst_a_e2", wa(1), 10'h354);
        check("post_rst_b_e2", wb(1), 10'h3FF);
        step();
        check("post_rst_a_e3", wa(1), 10'h100);

        de = 1'b0; fb = 1'b0;
        repeat (4) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
